// File: rtl/mux_spi_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mux_spi_chain_ctrl
//  Description : Daisy-chain SPI (mode 0) controller for N_DEV analog-mux
//                devices selecting EIT drive/sense electrode pairs. Shifts a
//                full chain frame MSB-first, captures MISO as readback,
//                mirrors the frame on parallel GPIO selects once the chain
//                has latched it, then waits for analog settle before done.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_spi_chain_ctrl #(
    parameter int N_DEV      = 4,
    parameter int DEV_W      = 8,
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int SETTLE_CYC = 16,
    localparam int FRAME_W   = N_DEV * DEV_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [FRAME_W-1:0] cfg_data_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               aborted_o,
    output logic [FRAME_W-1:0] rdback_o,
    output logic               spi_sclk_o,
    output logic               spi_mosi_o,
    input  logic               spi_miso_i,
    output logic               spi_cs_n_o,
    output logic [FRAME_W-1:0] gpio_mux_o
);

    // Counter widths: the divider and the shared phase timer only need to
    // reach their own terminal counts; the bit counter spans 0..FRAME_W-1.
    localparam int C_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int C_BIT_W   = $clog2(FRAME_W + 1);
    localparam int C_CS_MAX  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int C_TMR_MAX = (C_CS_MAX > SETTLE_CYC) ? C_CS_MAX : SETTLE_CYC;
    localparam int C_TMR_W   = (C_TMR_MAX > 1) ? $clog2(C_TMR_MAX) : 1;

    localparam logic [C_DIV_W-1:0] C_DIV_LAST    = C_DIV_W'(CLK_DIV - 1);
    localparam logic [C_BIT_W-1:0] C_BIT_LAST    = C_BIT_W'(FRAME_W - 1);
    localparam logic [C_TMR_W-1:0] C_SETUP_LAST  = C_TMR_W'(CS_SETUP - 1);
    localparam logic [C_TMR_W-1:0] C_HOLD_LAST   = C_TMR_W'(CS_HOLD - 1);
    localparam logic [C_TMR_W-1:0] C_SETTLE_LAST =
        C_TMR_W'((SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_SHIFT  = 3'd2,
        S_HOLD   = 3'd3,
        S_SETTLE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t               state_q;
    logic [FRAME_W-1:0]   frame_q;     // frame as accepted; drives gpio mirror
    logic [FRAME_W-1:0]   shreg_q;     // working copy shifted toward MSB
    logic [FRAME_W-1:0]   cap_q;       // MISO capture, fills from LSB
    logic [C_DIV_W-1:0]   div_q;
    logic [C_BIT_W-1:0]   bitcnt_q;
    logic [C_TMR_W-1:0]   tmr_q;
    logic                 sclk_q;
    logic                 mosi_q;
    logic                 cs_n_q;
    logic                 done_q;
    logic                 aborted_q;
    logic                 ready_q;
    logic                 busy_q;
    logic [FRAME_W-1:0]   gpio_q;
    logic [FRAME_W-1:0]   rdback_q;

    logic [FRAME_W-1:0]   shreg_d;
    logic [FRAME_W-1:0]   cap_d;
    logic                 abort_d;

    // Next values of the data shifters and the abort qualifier (abort only
    // counts while the chain select is asserted).
    always_comb begin
        shreg_d = shreg_q << 1;
        cap_d   = (cap_q << 1) | FRAME_W'(spi_miso_i);
        abort_d = abort_i && ((state_q == S_SETUP) || (state_q == S_SHIFT) ||
                              (state_q == S_HOLD));
    end

    // Transfer sequencer with all SPI and handshake outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            shreg_q   <= '0;
            cap_q     <= '0;
            div_q     <= '0;
            bitcnt_q  <= '0;
            tmr_q     <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            gpio_q    <= '0;
            rdback_q  <= '0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            if (abort_d) begin
                // Cancel: release the chain at once; mirror/readback keep
                // the last good configuration.
                state_q   <= S_DONE;
                cs_n_q    <= 1'b1;
                sclk_q    <= 1'b0;
                mosi_q    <= 1'b0;
                done_q    <= 1'b1;
                aborted_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            frame_q <= cfg_data_i;
                            shreg_q <= cfg_data_i;
                            mosi_q  <= cfg_data_i[FRAME_W-1];
                            cs_n_q  <= 1'b0;
                            tmr_q   <= '0;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= S_SETUP;
                        end
                    end
                    S_SETUP: begin
                        if (tmr_q == C_SETUP_LAST) begin
                            div_q    <= '0;
                            bitcnt_q <= '0;
                            state_q  <= S_SHIFT;
                        end else begin
                            tmr_q <= tmr_q + 1'b1;
                        end
                    end
                    S_SHIFT: begin
                        if (div_q == C_DIV_LAST) begin
                            div_q <= '0;
                            if (!sclk_q) begin
                                // Rising edge: devices sample MOSI, we sample MISO.
                                sclk_q <= 1'b1;
                                cap_q  <= cap_d;
                            end else begin
                                sclk_q <= 1'b0;
                                if (bitcnt_q == C_BIT_LAST) begin
                                    tmr_q   <= '0;
                                    state_q <= S_HOLD;
                                end else begin
                                    bitcnt_q <= bitcnt_q + 1'b1;
                                    shreg_q  <= shreg_d;
                                    mosi_q   <= shreg_d[FRAME_W-1];
                                end
                            end
                        end else begin
                            div_q <= div_q + 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (tmr_q == C_HOLD_LAST) begin
                            // cs_n rise latches the chain; mirror it on GPIO now.
                            cs_n_q   <= 1'b1;
                            mosi_q   <= 1'b0;
                            gpio_q   <= frame_q;
                            rdback_q <= cap_q;
                            tmr_q    <= '0;
                            if (SETTLE_CYC == 0) begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                state_q <= S_SETTLE;
                            end
                        end else begin
                            tmr_q <= tmr_q + 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (tmr_q == C_SETTLE_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            tmr_q <= tmr_q + 1'b1;
                        end
                    end
                    S_DONE: begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        cs_n_q  <= 1'b1;
                        sclk_q  <= 1'b0;
                        mosi_q  <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ready_o    = ready_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign aborted_o  = aborted_q;
    assign rdback_o   = rdback_q;
    assign spi_sclk_o = sclk_q;
    assign spi_mosi_o = mosi_q;
    assign spi_cs_n_o = cs_n_q;
    assign gpio_mux_o = gpio_q;

endmodule
`default_nettype wire
